// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl_if
// Brief    : Data-memory handshake bus between the LSU and data memory.
// Revision : 1.0  initial release
// ============================================================================
interface lsu_mem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Brief    : SPARC load/store unit: alignment check, big-endian lanes,
//            load extension and LDD/STD split into two word transfers.
// Revision : 1.0  initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    input  wire logic [5:0]  OpCode,
    input  wire logic [31:0] ea,
    input  wire logic [31:0] st_data0,
    input  wire logic [31:0] st_data1,
    output logic             busy,
    output logic             done,
    output logic [31:0]      ld_data0,
    output logic [31:0]      ld_data1,
    output logic             trap_align,
    output logic             trap_illop,
    output logic             trap_bus,
    lsu_mem_ctrl_if.master   mem
);
    localparam int         c_WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [1:0] c_SZ_B = 2'd0;
    localparam logic [1:0] c_SZ_H = 2'd1;
    localparam logic [1:0] c_SZ_W = 2'd2;
    localparam logic [1:0] c_SZ_D = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [1:0]            r_size;
    logic                  r_sgn;
    logic                  r_st;
    logic [31:0]           r_ea;
    logic [31:0]           r_sd1;
    logic [c_WAIT_W-1:0]   r_wait;
    logic                  r_busy, r_done, r_trap_align, r_trap_illop, r_trap_bus;
    logic [31:0]           r_ld0, r_ld1;
    logic                  r_req, r_we;
    logic [31:0]           r_addr, r_wdata;
    logic [3:0]            r_be;

    logic                  w_legal, w_sgn, w_st, w_misalign, w_timeout;
    logic [1:0]            w_size;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata, w_ld_ext;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    // Opcode decode and store lane generation act on the live request inputs.
    always_comb begin
        w_legal = 1'b1;
        w_size  = c_SZ_W;
        w_sgn   = 1'b0;
        w_st    = 1'b0;
        case (OpCode)
            6'b001001: begin w_size = c_SZ_B; w_sgn = 1'b1; end
            6'b001010: begin w_size = c_SZ_H; w_sgn = 1'b1; end
            6'b001000: w_size = c_SZ_W;
            6'b000001: w_size = c_SZ_B;
            6'b000010: w_size = c_SZ_H;
            6'b000011: w_size = c_SZ_D;
            6'b000101: begin w_size = c_SZ_B; w_st = 1'b1; end
            6'b000110: begin w_size = c_SZ_H; w_st = 1'b1; end
            6'b000100: begin w_size = c_SZ_W; w_st = 1'b1; end
            6'b000111: begin w_size = c_SZ_D; w_st = 1'b1; end
            default:   w_legal = 1'b0;
        endcase

        case (w_size)
            c_SZ_B:  w_misalign = 1'b0;
            c_SZ_H:  w_misalign = ea[0];
            c_SZ_W:  w_misalign = |ea[1:0];
            default: w_misalign = |ea[2:0];
        endcase

        w_be    = 4'b1111;
        w_wdata = 32'd0;
        if (w_st) begin
            case (w_size)
                c_SZ_B: begin
                    w_be    = 4'b1000 >> ea[1:0];
                    w_wdata = {4{st_data0[7:0]}};
                end
                c_SZ_H: begin
                    w_be    = ea[1] ? 4'b0011 : 4'b1100;
                    w_wdata = {2{st_data0[15:0]}};
                end
                default: w_wdata = st_data0;
            endcase
        end
    end

    // Byte 0 sits in bits 31:24 (big-endian).
    always_comb begin
        case (r_ea[1:0])
            2'd0:    w_byte = mem.mem_rdata[31:24];
            2'd1:    w_byte = mem.mem_rdata[23:16];
            2'd2:    w_byte = mem.mem_rdata[15:8];
            default: w_byte = mem.mem_rdata[7:0];
        endcase
        w_half = r_ea[1] ? mem.mem_rdata[15:0] : mem.mem_rdata[31:16];
        case (r_size)
            c_SZ_B:  w_ld_ext = {{24{r_sgn & w_byte[7]}}, w_byte};
            c_SZ_H:  w_ld_ext = {{16{r_sgn & w_half[15]}}, w_half};
            default: w_ld_ext = mem.mem_rdata;
        endcase
    end

    assign w_timeout = (TIMEOUT != 0) && !mem.mem_ack && (r_wait == c_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_size       <= c_SZ_B;
            r_sgn        <= 1'b0;
            r_st         <= 1'b0;
            r_ea         <= 32'd0;
            r_sd1        <= 32'd0;
            r_wait       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_trap_align <= 1'b0;
            r_trap_illop <= 1'b0;
            r_trap_bus   <= 1'b0;
            r_ld0        <= 32'd0;
            r_ld1        <= 32'd0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_be         <= 4'd0;
            r_wdata      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_size <= w_size;
                        r_sgn  <= w_sgn;
                        r_st   <= w_st;
                        r_ea   <= ea;
                        r_sd1  <= st_data1;
                        r_busy <= 1'b1;
                        r_ld0  <= 32'd0;
                        r_ld1  <= 32'd0;
                        if (!w_legal) begin
                            r_trap_illop <= 1'b1;
                            r_done       <= 1'b1;
                            r_state      <= S_DONE;
                        end else if (w_misalign) begin
                            r_trap_align <= 1'b1;
                            r_done       <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_wait  <= '0;
                            r_req   <= 1'b1;
                            r_we    <= w_st;
                            r_addr  <= {ea[31:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_state <= S_ACC0;
                        end
                    end
                end
                S_ACC0, S_ACC1: begin
                    if (mem.mem_ack) begin
                        if (!r_st && r_state == S_ACC0) r_ld0 <= w_ld_ext;
                        if (!r_st && r_state == S_ACC1) r_ld1 <= mem.mem_rdata;
                        if (r_state == S_ACC0 && r_size == c_SZ_D) begin
                            r_wait  <= '0;
                            r_addr  <= r_ea + 32'd4;
                            r_wdata <= r_sd1;
                            r_state <= S_ACC1;
                        end else begin
                            r_req   <= 1'b0;
                            r_we    <= 1'b0;
                            r_addr  <= 32'd0;
                            r_be    <= 4'd0;
                            r_wdata <= 32'd0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else if (w_timeout) begin
                        // Abort discards any word already captured by a double load.
                        r_req      <= 1'b0;
                        r_we       <= 1'b0;
                        r_addr     <= 32'd0;
                        r_be       <= 4'd0;
                        r_wdata    <= 32'd0;
                        r_ld0      <= 32'd0;
                        r_ld1      <= 32'd0;
                        r_trap_bus <= 1'b1;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: begin
                    r_done       <= 1'b0;
                    r_trap_align <= 1'b0;
                    r_trap_illop <= 1'b0;
                    r_trap_bus   <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign ld_data0      = r_ld0;
    assign ld_data1      = r_ld1;
    assign trap_align    = r_trap_align;
    assign trap_illop    = r_trap_illop;
    assign trap_bus      = r_trap_bus;
    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_be    = r_be;
    assign mem.mem_wdata = r_wdata;
endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Brief    : Directed self-checking bench for lsu_mem_ctrl (TIMEOUT = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  OpCode;
    logic [31:0] ea, st_data0, st_data1;
    logic        busy, done, trap_align, trap_illop, trap_bus;
    logic [31:0] ld_data0, ld_data1;
    int          n_cmp = 0;
    int          n_bad = 0;

    lsu_mem_ctrl_if mif();

    lsu_mem_ctrl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .OpCode     (OpCode),
        .ea         (ea),
        .st_data0   (st_data0),
        .st_data1   (st_data1),
        .busy       (busy),
        .done       (done),
        .ld_data0   (ld_data0),
        .ld_data1   (ld_data1),
        .trap_align (trap_align),
        .trap_illop (trap_illop),
        .trap_bus   (trap_bus),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request across one edge (edge 0); returns in cycle 1.
    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] s0, input logic [31:0] s1);
        OpCode = op; ea = a; st_data0 = s0; st_data1 = s1; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] rd);
        mif.mem_ack = 1'b1; mif.mem_rdata = rd;
        step();
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0h exp=0", done); end
        n_cmp++; if (mif.mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%0h exp=0", mif.mem_req); end
        n_cmp++; if (ld_data0 !== 32'd0) begin n_bad++; $display("FAIL reset_ld0 got=%h exp=0", ld_data0); end
        n_cmp++; if ({mif.mem_be, mif.mem_addr} !== 36'd0) begin n_bad++; $display("FAIL reset_bus got=%h exp=0", {mif.mem_be, mif.mem_addr}); end
    endtask

    task automatic test_ldub();
        issue(6'b000001, 32'h103, 32'd0, 32'd0);
        n_cmp++; if (mif.mem_req !== 1'b1) begin n_bad++; $display("FAIL ldub_req got=%0h exp=1", mif.mem_req); end
        n_cmp++; if (mif.mem_addr !== 32'h100) begin n_bad++; $display("FAIL ldub_addr got=%h exp=00000100", mif.mem_addr); end
        n_cmp++; if (mif.mem_be !== 4'b1111) begin n_bad++; $display("FAIL ldub_be got=%b exp=1111", mif.mem_be); end
        n_cmp++; if (mif.mem_we !== 1'b0) begin n_bad++; $display("FAIL ldub_we got=%0h exp=0", mif.mem_we); end
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL ldub_c1 busy/done got=%0h/%0h exp=1/0", busy, done); end
        ack_now(32'h112233F4);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ldub_done_c2 got=%0h exp=1", done); end
        n_cmp++; if (ld_data0 !== 32'h000000F4) begin n_bad++; $display("FAIL ldub_ld0 got=%h exp=000000f4", ld_data0); end
        n_cmp++; if (ld_data1 !== 32'd0) begin n_bad++; $display("FAIL ldub_ld1 got=%h exp=0", ld_data1); end
        n_cmp++; if ({trap_align, trap_illop, trap_bus, mif.mem_req} !== 4'b0) begin n_bad++; $display("FAIL ldub_traps got=%b exp=0000", {trap_align, trap_illop, trap_bus, mif.mem_req}); end
        step();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL ldub_c3 done/busy got=%0h/%0h exp=0/0", done, busy); end
    endtask

    task automatic test_lanes();
        issue(6'b001010, 32'h202, 32'd0, 32'd0);
        ack_now(32'h0000_8001);
        n_cmp++; if (ld_data0 !== 32'hFFFF8001) begin n_bad++; $display("FAIL ldsh_ld0 got=%h exp=ffff8001", ld_data0); end
        step();
        issue(6'b001001, 32'h101, 32'd0, 32'd0);
        ack_now(32'h1280_3456);
        n_cmp++; if (ld_data0 !== 32'hFFFFFF80) begin n_bad++; $display("FAIL ldsb_ld0 got=%h exp=ffffff80", ld_data0); end
        step();
        issue(6'b000110, 32'h202, 32'hABCD1234, 32'd0);
        n_cmp++; if (mif.mem_be !== 4'b0011) begin n_bad++; $display("FAIL sth_be got=%b exp=0011", mif.mem_be); end
        n_cmp++; if (mif.mem_wdata !== 32'h12341234) begin n_bad++; $display("FAIL sth_wdata got=%h exp=12341234", mif.mem_wdata); end
        n_cmp++; if (mif.mem_we !== 1'b1 || mif.mem_addr !== 32'h200) begin n_bad++; $display("FAIL sth_we_addr got=%0h/%h exp=1/00000200", mif.mem_we, mif.mem_addr); end
        ack_now(32'hDEADBEEF);
        n_cmp++; if (done !== 1'b1 || ld_data0 !== 32'd0) begin n_bad++; $display("FAIL sth_done got=%0h/%h exp=1/0", done, ld_data0); end
        step();
        issue(6'b000101, 32'h101, 32'h0000005A, 32'd0);
        n_cmp++; if (mif.mem_be !== 4'b0100 || mif.mem_wdata !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL stb_lanes got=%b/%h exp=0100/5a5a5a5a", mif.mem_be, mif.mem_wdata); end
        ack_now(32'd0);
        step();
    endtask

    task automatic test_ldd();
        issue(6'b000011, 32'h408, 32'd0, 32'd0);
        n_cmp++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h408) begin n_bad++; $display("FAIL ldd_c1 got=%0h/%h exp=1/00000408", mif.mem_req, mif.mem_addr); end
        step();
        n_cmp++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h408) begin n_bad++; $display("FAIL ldd_c2 got=%0h/%h exp=1/00000408", mif.mem_req, mif.mem_addr); end
        ack_now(32'hCAFE0001);
        n_cmp++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h40C) begin n_bad++; $display("FAIL ldd_c3 got=%0h/%h exp=1/0000040c", mif.mem_req, mif.mem_addr); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ldd_done_c4 got=%0h exp=0", done); end
        ack_now(32'hCAFE0002);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ldd_done_c5 got=%0h exp=1", done); end
        n_cmp++; if (ld_data0 !== 32'hCAFE0001 || ld_data1 !== 32'hCAFE0002) begin n_bad++; $display("FAIL ldd_data got=%h/%h exp=cafe0001/cafe0002", ld_data0, ld_data1); end
        step();
    endtask

    task automatic test_traps();
        issue(6'b000100, 32'h301, 32'h11111111, 32'd0);
        n_cmp++; if (done !== 1'b1 || trap_align !== 1'b1) begin n_bad++; $display("FAIL st_align got=%0h/%0h exp=1/1", done, trap_align); end
        n_cmp++; if ({trap_illop, trap_bus, mif.mem_req} !== 3'b0) begin n_bad++; $display("FAIL st_align_other got=%b exp=000", {trap_illop, trap_bus, mif.mem_req}); end
        step();
        n_cmp++; if (mif.mem_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL st_align_after got=%0h/%0h exp=0/0", mif.mem_req, busy); end
        issue(6'b111111, 32'h300, 32'd0, 32'd0);
        n_cmp++; if ({done, trap_illop, trap_align, trap_bus} !== 4'b1100) begin n_bad++; $display("FAIL illop got=%b exp=1100", {done, trap_illop, trap_align, trap_bus}); end
        step();
        issue(6'b000011, 32'h404, 32'd0, 32'd0);
        n_cmp++; if ({done, trap_align, mif.mem_req} !== 3'b110) begin n_bad++; $display("FAIL ldd_align got=%b exp=110", {done, trap_align, mif.mem_req}); end
        step();
    endtask

    task automatic test_timeout();
        int n_req;
        int done_cyc;
        n_req = 0; done_cyc = 0;
        issue(6'b001000, 32'h700, 32'd0, 32'd0);
        for (int c = 1; c <= 10; c++) begin
            if (mif.mem_req === 1'b1) n_req++;
            if (done === 1'b1) begin
                done_cyc = c;
                n_cmp++; if ({trap_bus, trap_align, trap_illop} !== 3'b100 || ld_data0 !== 32'd0) begin n_bad++; $display("FAIL to_traps got=%b/%h exp=100/0", {trap_bus, trap_align, trap_illop}, ld_data0); end
                break;
            end
            if (c == 2) begin
                OpCode = 6'b000100; ea = 32'h800; start = 1'b1;
            end
            step();
            start = 1'b0;
        end
        n_cmp++; if (n_req != 4) begin n_bad++; $display("FAIL to_req_cycles got=%0d exp=4", n_req); end
        n_cmp++; if (done_cyc != 5) begin n_bad++; $display("FAIL to_done_cycle got=%0d exp=5", done_cyc); end
        step();
        step();
        n_cmp++; if (busy !== 1'b0 || mif.mem_req !== 1'b0) begin n_bad++; $display("FAIL busy_start_ignored got=%0h/%0h exp=0/0", busy, mif.mem_req); end
        // Double load: first word returned, second never acked.
        n_req = 0; done_cyc = 0;
        issue(6'b000011, 32'h900, 32'd0, 32'd0);
        ack_now(32'h12345678);
        for (int c = 2; c <= 12; c++) begin
            if (mif.mem_req === 1'b1) n_req++;
            if (done === 1'b1) begin
                done_cyc = c;
                n_cmp++; if (trap_bus !== 1'b1 || ld_data0 !== 32'd0 || ld_data1 !== 32'd0) begin n_bad++; $display("FAIL ldd_to got=%0h/%h/%h exp=1/0/0", trap_bus, ld_data0, ld_data1); end
                break;
            end
            step();
        end
        n_cmp++; if (n_req != 4 || done_cyc != 6) begin n_bad++; $display("FAIL ldd_to_timing got=%0d/%0d exp=4/6", n_req, done_cyc); end
        step();
    endtask

    task automatic test_reset_mid();
        issue(6'b000111, 32'h500, 32'hAAAA0000, 32'hBBBB1111);
        n_cmp++; if (mif.mem_wdata !== 32'hAAAA0000 || mif.mem_we !== 1'b1 || mif.mem_be !== 4'hF) begin n_bad++; $display("FAIL std_w0 got=%h/%0h/%b exp=aaaa0000/1/1111", mif.mem_wdata, mif.mem_we, mif.mem_be); end
        ack_now(32'd0);
        n_cmp++; if (mif.mem_addr !== 32'h504 || mif.mem_wdata !== 32'hBBBB1111) begin n_bad++; $display("FAIL std_w1 got=%h/%h exp=00000504/bbbb1111", mif.mem_addr, mif.mem_wdata); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if ({mif.mem_req, busy, done} !== 3'b000) begin n_bad++; $display("FAIL mid_reset got=%b exp=000", {mif.mem_req, busy, done}); end
        issue(6'b001000, 32'h600, 32'd0, 32'd0);
        n_cmp++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h600) begin n_bad++; $display("FAIL post_reset_req got=%0h/%h exp=1/00000600", mif.mem_req, mif.mem_addr); end
        ack_now(32'h0BADF00D);
        n_cmp++; if (done !== 1'b1 || ld_data0 !== 32'h0BADF00D) begin n_bad++; $display("FAIL post_reset_ld got=%0h/%h exp=1/0badf00d", done, ld_data0); end
        step();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; OpCode = 6'd0; ea = 32'd0;
        st_data0 = 32'd0; st_data1 = 32'd0;
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'd0;
        test_reset();
        test_ldub();
        test_lanes();
        test_ldd();
        test_traps();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
